// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Fixed-latency data-memory slave with a word array and byte-lane stores.
// Rev     : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  logic [1:0]  dmem_size,
    input  logic        dmem_wr_en,
    input  logic [31:0] dmem_wr_data,
    input  logic        dmem_zero_extend,
    output logic        dmem_ready,
    output logic        dmem_rsp_valid,
    output logic [31:0] dmem_rd_data,
    output logic        dmem_err
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        zext_q, zext_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;

    logic          accept;
    logic          align_err;
    logic          range_err;
    logic          err;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wr_word;
    logic          mem_we;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_data;

    assign dmem_ready     = (state_q == IDLE) && !reset;
    assign dmem_rsp_valid = (state_q == RESP) && !reset;
    assign accept         = dmem_req && dmem_ready;
    assign idx            = addr_q[AW+1:2];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        zext_d    = zext_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ACCESS;
                    addr_d    = dmem_addr;
                    size_d    = dmem_size;
                    wr_en_d   = dmem_wr_en;
                    wr_data_d = dmem_wr_data;
                    zext_d    = dmem_zero_extend;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Fault decode works off the captured request, so it is stable through ACCESS and RESP.
    always_comb begin
        align_err = 1'b0;
        be        = 4'b0000;
        wr_word   = dmem_wr_data;
        case (size_q)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_word = {4{wr_data_q[7:0]}};
            end
            SZ_HALF: begin
                align_err = addr_q[0];
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word   = {2{wr_data_q[15:0]}};
            end
            SZ_WORD: begin
                align_err = |addr_q[1:0];
                be        = 4'b1111;
                wr_word   = wr_data_q;
            end
            default: align_err = 1'b1;
        endcase
        range_err = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        err       = align_err || range_err;
        mem_we    = (state_q == ACCESS) && wr_en_q && !err && !reset;
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = rd_word_q[7:0];
            2'd1:    ld_byte = rd_word_q[15:8];
            2'd2:    ld_byte = rd_word_q[23:16];
            default: ld_byte = rd_word_q[31:24];
        endcase
        ld_half = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (size_q)
            SZ_BYTE: load_data = {{24{ld_byte[7] & ~zext_q}}, ld_byte};
            SZ_HALF: load_data = {{16{ld_half[15] & ~zext_q}}, ld_half};
            default: load_data = rd_word_q;
        endcase
    end

    assign dmem_rd_data = (dmem_rsp_valid && !err && !wr_en_q) ? load_data : 32'd0;
    assign dmem_err     = dmem_rsp_valid && err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
        addr_q    <= addr_d;
        size_q    <= size_d;
        wr_en_q   <= wr_en_d;
        wr_data_q <= wr_data_d;
        zext_q    <= zext_d;
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
        if (state_q == ACCESS) begin
            rd_word_q <= mem[idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Directed vector bench for dmem_responder.
// Rev     : 1.0
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [1:0]  dmem_size;
    logic        dmem_wr_en;
    logic [31:0] dmem_wr_data;
    logic        dmem_zero_extend;
    logic        dmem_ready;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rd_data;
    logic        dmem_err;

    int n_cmp;
    int n_bad;

    dmem_responder #(.DEPTH_WORDS(1024)) dut (
        .clk              (clk),
        .reset            (reset),
        .dmem_req         (dmem_req),
        .dmem_addr        (dmem_addr),
        .dmem_size        (dmem_size),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_ready       (dmem_ready),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rd_data     (dmem_rd_data),
        .dmem_err         (dmem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic        zx;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [0:NV-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, then scrambles the inputs after accept and checks N+1..N+3.
    task automatic txn(input string nm, input logic [31:0] a, input logic [1:0] s,
                       input logic w, input logic [31:0] d, input logic zx,
                       input logic [31:0] exp_rd, input logic exp_err);
        int waitc;
        waitc            = 0;
        dmem_req         = 1'b1;
        dmem_addr        = a;
        dmem_size        = s;
        dmem_wr_en       = w;
        dmem_wr_data     = d;
        dmem_zero_extend = zx;
        while (!dmem_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        if (!dmem_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept_timeout: ready=%0b, required 1", nm, dmem_ready);
            dmem_req = 1'b0;
            return;
        end
        tick();
        dmem_req         = 1'b0;
        dmem_addr        = ~a;
        dmem_size        = ~s;
        dmem_wr_en       = ~w;
        dmem_wr_data     = ~d;
        dmem_zero_extend = ~zx;
        chk({nm, " n1_valid"}, {31'd0, dmem_rsp_valid}, 32'd0);
        tick();
        chk({nm, " n2_valid"}, {31'd0, dmem_rsp_valid}, 32'd1);
        chk({nm, " rd_data"}, dmem_rd_data, exp_rd);
        chk({nm, " err"}, {31'd0, dmem_err}, {31'd0, exp_err});
        tick();
        chk({nm, " n3_valid"}, {31'd0, dmem_rsp_valid}, 32'd0);
        chk({nm, " n3_rd_zero"}, dmem_rd_data, 32'd0);
        chk({nm, " n3_ready"}, {31'd0, dmem_ready}, 32'd1);
    endtask

    logic [1:0] exp_ready_pat [0:5];
    logic [1:0] exp_valid_pat [0:5];

    initial begin
        n_cmp            = 0;
        n_bad            = 0;
        reset            = 1'b1;
        dmem_req         = 1'b0;
        dmem_addr        = 32'd0;
        dmem_size        = 2'b10;
        dmem_wr_en       = 1'b0;
        dmem_wr_data     = 32'd0;
        dmem_zero_extend = 1'b0;

        //               addr          size   wr    wdata         zx    exp_rd        err
        vecs[0]  = '{32'h0000_0010, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h0000_0011, 2'b00, 1'b1, 32'h0000_00A5, 1'b0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b0, 32'hDEAD_A5EF, 1'b0};
        vecs[4]  = '{32'h0000_0011, 2'b00, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFA5, 1'b0};
        vecs[5]  = '{32'h0000_0011, 2'b00, 1'b0, 32'h0,         1'b1, 32'h0000_00A5, 1'b0};
        vecs[6]  = '{32'h0000_0012, 2'b01, 1'b1, 32'h0000_8001, 1'b0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{32'h0000_0012, 2'b01, 1'b0, 32'h0,         1'b0, 32'hFFFF_8001, 1'b0};
        vecs[8]  = '{32'h0000_0012, 2'b01, 1'b0, 32'h0,         1'b1, 32'h0000_8001, 1'b0};
        vecs[9]  = '{32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b0, 32'h8001_A5EF, 1'b0};
        vecs[10] = '{32'h0000_0010, 2'b00, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFEF, 1'b0};
        vecs[11] = '{32'h0000_0013, 2'b00, 1'b0, 32'h0,         1'b0, 32'hFFFF_FF80, 1'b0};
        vecs[12] = '{32'h0000_0012, 2'b00, 1'b0, 32'h0,         1'b1, 32'h0000_0001, 1'b0};
        vecs[13] = '{32'h0000_0010, 2'b01, 1'b0, 32'h0,         1'b0, 32'hFFFF_A5EF, 1'b0};
        vecs[14] = '{32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b1, 32'h8001_A5EF, 1'b0};
        vecs[15] = '{32'h0000_0013, 2'b10, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
        vecs[16] = '{32'h0000_0011, 2'b01, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b1};
        vecs[17] = '{32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b0, 32'h8001_A5EF, 1'b0};
        vecs[18] = '{32'h0000_0000, 2'b10, 1'b1, 32'h1111_2222, 1'b0, 32'h0000_0000, 1'b0};
        vecs[19] = '{32'h0000_1000, 2'b10, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
        vecs[20] = '{32'h0000_1000, 2'b10, 1'b1, 32'hBADB_AD00, 1'b0, 32'h0000_0000, 1'b1};
        vecs[21] = '{32'h0000_0000, 2'b10, 1'b0, 32'h0,         1'b0, 32'h1111_2222, 1'b0};
        vecs[22] = '{32'h0000_0010, 2'b11, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
        vecs[23] = '{32'h0000_0010, 2'b11, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
        vecs[24] = '{32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b0, 32'h8001_A5EF, 1'b0};
        vecs[25] = '{32'h0000_0011, 2'b01, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
        vecs[26] = '{32'hFFFF_FFFC, 2'b10, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1};
        vecs[27] = '{32'h0000_0020, 2'b10, 1'b1, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0};
        vecs[28] = '{32'h0000_0020, 2'b10, 1'b0, 32'h0,         1'b0, 32'h1234_5678, 1'b0};
        vecs[29] = '{32'h0000_0022, 2'b00, 1'b1, 32'hFFFF_FF77, 1'b0, 32'h0000_0000, 1'b0};
        vecs[30] = '{32'h0000_0020, 2'b10, 1'b0, 32'h0,         1'b0, 32'h1277_5678, 1'b0};
        vecs[31] = '{32'h0000_0020, 2'b01, 1'b1, 32'hABCD_9999, 1'b0, 32'h0000_0000, 1'b0};
        vecs[32] = '{32'h0000_0020, 2'b10, 1'b0, 32'h0,         1'b0, 32'h1277_9999, 1'b0};

        exp_ready_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
        exp_valid_pat = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};

        // Reset state
        repeat (3) tick();
        chk("rst ready", {31'd0, dmem_ready}, 32'd0);
        chk("rst rsp_valid", {31'd0, dmem_rsp_valid}, 32'd0);
        chk("rst rd_data", dmem_rd_data, 32'd0);
        chk("rst err", {31'd0, dmem_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst ready", {31'd0, dmem_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size, vecs[i].wr,
                vecs[i].wdata, vecs[i].zx, vecs[i].exp_rd, vecs[i].exp_err);
        end

        // Back-to-back: request held high, address changed one cycle after accept.
        begin
            int accepts;
            accepts          = 0;
            dmem_req         = 1'b1;
            dmem_addr        = 32'h0000_0010;
            dmem_size        = 2'b10;
            dmem_wr_en       = 1'b0;
            dmem_zero_extend = 1'b0;
            for (int c = 0; c < 6; c++) begin
                chk($sformatf("b2b ready c%0d", c), {31'd0, dmem_ready}, {30'd0, exp_ready_pat[c]});
                chk($sformatf("b2b valid c%0d", c), {31'd0, dmem_rsp_valid}, {30'd0, exp_valid_pat[c]});
                if (c == 2) begin
                    chk("b2b rsp0 rd_data", dmem_rd_data, 32'h8001_A5EF);
                    chk("b2b rsp0 err", {31'd0, dmem_err}, 32'd0);
                end
                if (c == 5) begin
                    chk("b2b rsp1 rd_data", dmem_rd_data, 32'd0);
                    chk("b2b rsp1 err", {31'd0, dmem_err}, 32'd1);
                end
                if (dmem_req && dmem_ready) accepts++;
                tick();
                if (c == 0) dmem_addr = 32'h0000_0013;
            end
            dmem_req = 1'b0;
            chk("b2b accepts", accepts, 32'd2);
            tick();
        end

        // Reset during ACCESS aborts the store.
        begin
            int waitc;
            waitc        = 0;
            dmem_req     = 1'b1;
            dmem_addr    = 32'h0000_0020;
            dmem_size    = 2'b10;
            dmem_wr_en   = 1'b1;
            dmem_wr_data = 32'hCAFE_F00D;
            while (!dmem_ready && waitc < 20) begin
                tick();
                waitc++;
            end
            chk("abort accept_ready", {31'd0, dmem_ready}, 32'd1);
            tick();
            dmem_req = 1'b0;
            reset    = 1'b1;
            #1;
            chk("abort access ready", {31'd0, dmem_ready}, 32'd0);
            chk("abort access valid", {31'd0, dmem_rsp_valid}, 32'd0);
            tick();
            chk("abort n2 valid", {31'd0, dmem_rsp_valid}, 32'd0);
            chk("abort n2 ready", {31'd0, dmem_ready}, 32'd0);
            chk("abort n2 rd_data", dmem_rd_data, 32'd0);
            tick();
            reset = 1'b0;
            #1;
            chk("abort post_rst ready", {31'd0, dmem_ready}, 32'd1);
            txn("abort reload", 32'h0000_0020, 2'b10, 1'b0, 32'h0, 1'b0, 32'h1277_9999, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the internal data array (power of 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port dmem_req  input  1  request valid from the pipeline memory stage.
REQ-005 SHALL have port dmem_addr  input  32  byte address.
REQ-006 SHALL have port dmem_size  input  2  mem_size_t from risc_pkg: BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b10; 2'b11 is reserved.
REQ-007 SHALL have port dmem_wr_en  input  1  1 = store, 0 = load.
REQ-008 SHALL have port dmem_wr_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port dmem_zero_extend  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-010 SHALL have port dmem_ready  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port dmem_rsp_valid  output  1  one-cycle completion pulse for the accepted request.
REQ-012 SHALL have port dmem_rd_data  output  32  load result, valid while dmem_rsp_valid=1.
REQ-013 SHALL have port dmem_err  output  1  access fault, valid while dmem_rsp_valid=1.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on accept, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-015 SHALL drive dmem_ready=1 only in IDLE and only when reset=0; a request is accepted on a cycle where dmem_req=1 and dmem_ready=1.
REQ-016 SHALL register addr, size, wr_en, wr_data and zero_extend at accept; input changes after accept SHALL have no effect on that transaction.
REQ-017 SHALL ignore dmem_req while dmem_ready=0 (no queuing); the requester holds the request until accepted.
REQ-018 SHALL assert dmem_rsp_valid for exactly one cycle, in RESP, which is two cycles after the accept cycle N (response in cycle N+2), for both loads and stores; the next accept is possible no earlier than cycle N+3.
REQ-019 SHALL perform the array read in ACCESS as a synchronous word read at index addr[log2(DEPTH_WORDS)+1:2].
REQ-020 SHALL set err=1 for any of: HALF_WORD with addr[0]=1; WORD with addr[1:0]!=0; size=2'b11; addr[31:2] >= DEPTH_WORDS.
REQ-021 SHALL, on error, perform no array write and return dmem_rd_data=0 and dmem_err=1; the FSM timing is unchanged.
REQ-022 SHALL implement the load BYTE case: select lane addr[1:0] and extend bit 7 or zero-extend per zero_extend.
REQ-023 SHALL implement the load HALF_WORD case: select the half given by addr[1] and extend bit 15 or zero-extend per zero_extend.
REQ-024 SHALL implement the load WORD case: return the word unchanged, ignoring zero_extend.
REQ-025 SHALL commit stores at the ACCESS->RESP edge using byte enables: a BYTE store writes only lane addr[1:0]; a HALF_WORD store writes lanes {addr[1],0} and {addr[1],1}; a WORD store writes all 4 lanes; unselected bytes keep their contents.
REQ-026 SHALL return dmem_rd_data=0 for stores.
REQ-027 SHALL drive dmem_rd_data=0 and dmem_err=0 whenever dmem_rsp_valid=0.
REQ-028 SHALL make a load issued after a store's response observe the stored data (no stale read).

Reset
REQ-029 SHALL, while reset=1, force state=IDLE, dmem_ready=0, dmem_rsp_valid=0, dmem_rd_data=0 and dmem_err=0.
REQ-030 SHALL make dmem_ready=1 in the first cycle after reset deasserts.
REQ-031 SHALL abort the in-flight transaction when reset asserts in ACCESS or RESP: no array write, no dmem_rsp_valid.
REQ-032 SHALL not reset or initialise the data array contents.

Verification
REQ-033 The bench SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid at accept+2 each time, rd_data=0xDEADBEEF, err=0.
REQ-034 The bench SHALL cover: after REQ-033, SB addr 0x11 data 0x000000A5, then LW 0x10 -> 0xDEADA5EF; then LB 0x11 -> 0xFFFFFFA5, and LBU 0x11 -> 0x000000A5.
REQ-035 The bench SHALL cover: after REQ-034, SH addr 0x12 data 0x00008001, then LH 0x12 -> 0xFFFF8001, LHU 0x12 -> 0x00008001, and LW 0x10 -> 0x8001A5EF.
REQ-036 The bench SHALL cover: LW 0x13 -> err=1, rd_data=0; SH 0x11 then LW 0x10 -> err=1 on the SH and memory unchanged; access to address DEPTH_WORDS*4 -> err=1; size=2'b11 -> err=1.
REQ-037 The bench SHALL cover: dmem_req held high continuously -> dmem_ready toggles 1,0,0,1 and exactly one accept per 3 cycles; changing dmem_addr in cycle N+1 does not alter the response.
REQ-038 The bench SHALL cover: SW to 0x20 with reset asserted in the ACCESS cycle -> no rsp_valid and ready=0 during reset; after reset, LW 0x20 returns the pre-existing value (no write committed).
